i2c_slave: RTL and testbench

I2C target (slave) with an 8-bit register-pointer model, the responder that pairs with the team's I2C master on the same two-wire bus. Oversamples SCL/SDA on the system clock, detects START/STOP/repeated START, matches a 7-bit device address, and drives SDA open-drain for ACK and read data. A write stores byte 1 as the register pointer and later bytes as data. A read returns bytes from the pointer. The pointer auto-increments after every data byte. Register storage is external.

---
 rtl/i2c_slave_if.sv | 30 +++
 rtl/i2c_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
//------------------------------------------------------------------------------
// Module   : i2c_slave_if
// Brief    : Pad and register-file signals of the I2C target.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
  );

  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
  );
endinterface

`default_nettype wire

// File: rtl/i2c_slave.sv
//------------------------------------------------------------------------------
// Module   : i2c_slave
// Brief    : Oversampled I2C target with 8-bit auto-incrementing register pointer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_slave #(
  parameter logic [6:0] DEV_ADD = 7'h50
) (
  input  wire logic   clk,
  input  wire logic   reset,
  i2c_slave_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_WAIT     = 3'd7;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      r_scl_s1 <= bus.scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= bus.sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  assign w_sda      = r_sda_s2;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  logic [2:0] r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_rd_addr;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       r_wr_en, w_wr_en_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_first, w_first_nxt;
  logic       r_ackph, w_ackph_nxt;
  logic [7:0] w_byte;
  logic       w_last;

  assign w_byte = {r_shift[6:0], w_sda};
  assign w_last = (r_bitcnt == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bitcnt  <= 4'd0;
      r_ptr     <= 8'h00;
      r_rd_addr <= 8'h00;
      r_wr_addr <= 8'h00;
      r_wr_data <= 8'h00;
      r_wr_en   <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_first   <= 1'b0;
      r_ackph   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rd_addr <= r_ptr;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_rw      <= w_rw_nxt;
      r_first   <= w_first_nxt;
      r_ackph   <= w_ackph_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:     if (w_scl_rise && w_last)
                      w_state_nxt = (w_byte[7:1] == DEV_ADD) ? S_ADDR_ACK : S_WAIT;
        S_ADDR_ACK: if (w_scl_fall && r_ackph)
                      w_state_nxt = r_rw ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:  if (w_scl_rise && w_last) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall && r_ackph) w_state_nxt = S_WR_BYTE;
        S_RD_BYTE:  if (w_scl_fall && w_last) w_state_nxt = S_RD_ACK;
        // The fall seen here always follows a rise that sampled an ACK.
        S_RD_ACK: begin
          if (w_scl_rise && w_sda) w_state_nxt = S_WAIT;
          else if (w_scl_fall)     w_state_nxt = S_RD_BYTE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_ptr_nxt     = r_ptr;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_wr_en_nxt   = 1'b0;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_rw_nxt      = r_rw;
    w_first_nxt   = r_first;
    w_ackph_nxt   = r_ackph;
    if (w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_bitcnt_nxt = 4'd8;
      w_first_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_ackph_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt  = w_byte;
          w_bitcnt_nxt = r_bitcnt - 4'd1;
          if (w_last) begin
            w_ackph_nxt = 1'b0;
            if (w_byte[7:1] == DEV_ADD) begin
              w_rw_nxt   = w_sda;
              w_busy_nxt = 1'b1;
            end else begin
              w_busy_nxt = 1'b0;
            end
          end
        end
        S_ADDR_ACK: if (w_scl_fall) begin
          if (!r_ackph) begin
            w_sda_oe_nxt = 1'b1;
            w_ackph_nxt  = 1'b1;
          end else begin
            w_ackph_nxt  = 1'b0;
            w_bitcnt_nxt = 4'd8;
            if (r_rw) begin
              w_shift_nxt  = bus.rd_data;
              w_sda_oe_nxt = ~bus.rd_data[7];
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_first_nxt  = 1'b1;
            end
          end
        end
        S_WR_BYTE: if (w_scl_rise) begin
          w_shift_nxt  = w_byte;
          w_bitcnt_nxt = r_bitcnt - 4'd1;
          if (w_last) begin
            w_ackph_nxt = 1'b0;
            if (r_first) begin
              w_ptr_nxt   = w_byte;
              w_first_nxt = 1'b0;
            end else begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = r_ptr;
              w_wr_data_nxt = w_byte;
              w_ptr_nxt     = r_ptr + 8'd1;
            end
          end
        end
        S_WR_ACK: if (w_scl_fall) begin
          w_sda_oe_nxt = ~r_ackph;
          w_ackph_nxt  = ~r_ackph;
          if (r_ackph) w_bitcnt_nxt = 4'd8;
        end
        S_RD_BYTE: if (w_scl_fall) begin
          if (w_last) begin
            w_sda_oe_nxt = 1'b0;
            w_ptr_nxt    = r_ptr + 8'd1;
          end else begin
            w_shift_nxt  = {r_shift[6:0], r_shift[7]};
            w_sda_oe_nxt = ~r_shift[6];
            w_bitcnt_nxt = r_bitcnt - 4'd1;
          end
        end
        S_RD_ACK: if (w_scl_fall) begin
          w_shift_nxt  = bus.rd_data;
          w_sda_oe_nxt = ~bus.rd_data[7];
          w_bitcnt_nxt = 4'd8;
        end
        default: w_sda_oe_nxt = 1'b0;
      endcase
    end
  end

  assign bus.sda_oe  = r_sda_oe;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.rd_addr = r_rd_addr;
  assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
//------------------------------------------------------------------------------
// Module   : tb_i2c_slave
// Brief    : Directed bus-master bench for i2c_slave with a simple register model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_slave;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r_scl_m = 1'b1;
  logic r_sda_m = 1'b1;
  logic w_sda_line;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] wr_a_q[$];
  logic [7:0] wr_d_q[$];
  logic r_oe_seen = 1'b0;
  logic r_busy_seen = 1'b0;

  i2c_slave_if bus();

  i2c_slave #(.DEV_ADD(7'h50)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign w_sda_line = r_sda_m & ~bus.sda_oe;
  assign bus.scl_in = r_scl_m;
  assign bus.sda_in = w_sda_line;

  always @(posedge clk) bus.rd_data <= bus.rd_addr ^ 8'hFF;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_a_q.push_back(bus.wr_addr);
      wr_d_q.push_back(bus.wr_data);
    end
    if (bus.sda_oe) r_oe_seen = 1'b1;
    if (bus.busy) r_busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    r_sda_m = 1'b1; r_scl_m = 1'b1; tick(Q);
    r_sda_m = 1'b0; tick(Q);
    r_scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    r_sda_m = 1'b1; tick(Q);
    r_scl_m = 1'b1; tick(Q);
    r_sda_m = 1'b0; tick(Q);
    r_scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    r_sda_m = 1'b0; tick(Q);
    r_scl_m = 1'b1; tick(Q);
    r_sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    r_sda_m = b; tick(Q);
    r_scl_m = 1'b1; tick(2 * Q);
    r_scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    r_sda_m = 1'b1; tick(Q);
    r_scl_m = 1'b1; tick(Q);
    b = w_sda_line; tick(Q);
    r_scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         nack;

    tick(5);
    reset = 1'b0;
    tick(2);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_busy", bus.busy, 0);

    // Pointer write then two data bytes
    bus_start();
    put_byte(8'hA0, ack); check("t1_addr_ack", ack, 1);
    check("t1_busy_hi", bus.busy, 1);
    put_byte(8'h10, ack); check("t1_ptr_ack", ack, 1);
    put_byte(8'hA5, ack); check("t1_d0_ack", ack, 1);
    put_byte(8'h3C, ack); check("t1_d1_ack", ack, 1);
    bus_stop();
    tick(6);
    check("t1_wr_count", wr_a_q.size(), 2);
    if (wr_a_q.size() == 2) begin
      check("t1_wa0", wr_a_q[0], 8'h10); check("t1_wd0", wr_d_q[0], 8'hA5);
      check("t1_wa1", wr_a_q[1], 8'h11); check("t1_wd1", wr_d_q[1], 8'h3C);
    end
    check("t1_rd_addr", bus.rd_addr, 8'h12);
    check("t1_busy_lo", bus.busy, 0);
    wr_a_q.delete(); wr_d_q.delete();

    // Pointer write, repeated START, read two bytes
    bus_start();
    put_byte(8'hA0, ack); check("t2_addr_ack", ack, 1);
    put_byte(8'h20, ack); check("t2_ptr_ack", ack, 1);
    bus_rstart();
    put_byte(8'hA1, ack); check("t2_raddr_ack", ack, 1);
    get_byte(d, 1'b1); check("t2_rd0", d, 8'hDF);
    get_byte(d, 1'b0); check("t2_rd1", d, 8'hDE);
    bus_stop();
    tick(6);
    check("t2_sda_oe", bus.sda_oe, 0);
    check("t2_busy_lo", bus.busy, 0);
    check("t2_rd_addr", bus.rd_addr, 8'h22);
    check("t2_wr_count", wr_a_q.size(), 0);

    // Address mismatch
    r_oe_seen = 1'b0; r_busy_seen = 1'b0; nack = 0;
    bus_start();
    put_byte(8'hA2, ack); nack += int'(ack);
    put_byte(8'h05, ack); nack += int'(ack);
    put_byte(8'h06, ack); nack += int'(ack);
    bus_stop();
    tick(6);
    check("t3_acks", nack, 0);
    check("t3_oe_seen", r_oe_seen, 0);
    check("t3_busy_seen", r_busy_seen, 0);
    check("t3_wr_count", wr_a_q.size(), 0);

    // Pointer wrap
    bus_start();
    put_byte(8'hA0, ack);
    put_byte(8'hFF, ack);
    put_byte(8'h01, ack);
    put_byte(8'h02, ack);
    put_byte(8'h03, ack); check("t4_last_ack", ack, 1);
    bus_stop();
    tick(6);
    check("t4_wr_count", wr_a_q.size(), 3);
    if (wr_a_q.size() == 3) begin
      check("t4_wa0", wr_a_q[0], 8'hFF); check("t4_wd0", wr_d_q[0], 8'h01);
      check("t4_wa1", wr_a_q[1], 8'h00); check("t4_wd1", wr_d_q[1], 8'h02);
      check("t4_wa2", wr_a_q[2], 8'h01); check("t4_wd2", wr_d_q[2], 8'h03);
    end
    check("t4_rd_addr", bus.rd_addr, 8'h02);
    wr_a_q.delete(); wr_d_q.delete();

    // STOP in the middle of a data byte
    bus_start();
    put_byte(8'hA0, ack);
    put_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) put_bit(i[0]);
    bus_stop();
    tick(6);
    check("t5_wr_count", wr_a_q.size(), 0);
    check("t5_rd_addr", bus.rd_addr, 8'h30);
    bus_start();
    put_byte(8'hA0, ack); check("t5_addr_ack", ack, 1);
    put_byte(8'h40, ack); check("t5_ptr_ack", ack, 1);
    put_byte(8'h77, ack); check("t5_d_ack", ack, 1);
    bus_stop();
    tick(6);
    check("t5_wr_count2", wr_a_q.size(), 1);
    if (wr_a_q.size() == 1) begin
      check("t5_wa", wr_a_q[0], 8'h40); check("t5_wd", wr_d_q[0], 8'h77);
    end
    wr_a_q.delete(); wr_d_q.delete();

    // Reset while the target is driving ACK
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    check("t6_ack_driven", bus.sda_oe, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("t6_sda_oe_rst", bus.sda_oe, 0);
    check("t6_rd_addr_rst", bus.rd_addr, 0);
    check("t6_busy_rst", bus.busy, 0);
    reset = 1'b0;
    tick(2);
    bus_stop();
    tick(4);
    bus_start();
    put_byte(8'hA0, ack); check("t6_addr_ack", ack, 1);
    bus_stop();
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
